// File: rtl/rename_stage.sv
// Register-rename stage: maps architectural sources/destination to physical
// registers through a RAT, allocates destinations from a circular free list
// refilled by the commit-side release port, and registers the result for dispatch.
module rename_stage #(
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5,
    parameter int FL_DEPTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [11:0]           pc_in,
    input  logic [31:0]           instr_in,
    input  logic [6:0]            c_sig_in,
    input  logic [2:0]            alu_sig_in,
    input  logic [31:0]           imm_in,
    input  logic                  ready_in,
    input  logic                  free_valid_in,
    input  logic [PREG_WIDTH-1:0] free_preg_in,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [11:0]           pc_out,
    output logic [31:0]           instr_out,
    output logic [6:0]            c_sig_out,
    output logic [2:0]            alu_sig_out,
    output logic [31:0]           imm_out,
    output logic [PREG_WIDTH-1:0] prs1_out,
    output logic [PREG_WIDTH-1:0] prs2_out,
    output logic [PREG_WIDTH-1:0] prd_out,
    output logic [PREG_WIDTH-1:0] old_prd_out
);

    localparam int PTR_W    = $clog2(FL_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_AREG = 2 ** AREG_WIDTH;

    logic [PREG_WIDTH-1:0] rat [NUM_AREG];
    logic [PREG_WIDTH-1:0] fl  [FL_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic [AREG_WIDTH-1:0] rs1;
    logic [AREG_WIDTH-1:0] rs2;
    logic [AREG_WIDTH-1:0] rd;
    logic                  needs_alloc;
    logic                  fl_empty;
    logic                  fl_full;
    logic                  fire;
    logic                  alloc;
    logic                  release_ok;
    logic [PREG_WIDTH-1:0] new_prd;
    logic [PREG_WIDTH-1:0] prev_prd;

    assign rs1 = instr_in[15 +: AREG_WIDTH];
    assign rs2 = instr_in[20 +: AREG_WIDTH];
    assign rd  = instr_in[7 +: AREG_WIDTH];

    // x0 is hardwired, so writes to it never consume a physical register
    assign needs_alloc = c_sig_in[0] & (rd != '0);
    assign fl_empty    = (count == '0);
    assign fl_full     = (count == CNT_W'(FL_DEPTH));

    // No bypass from the release port: an empty list stalls even if a release arrives
    assign fire       = valid_in & ready_in & ~(needs_alloc & fl_empty);
    assign stall_out  = valid_in & ~fire;
    assign alloc      = fire & needs_alloc;
    assign release_ok = free_valid_in & (free_preg_in != '0) & ~fl_full;

    assign new_prd  = fl[head];
    assign prev_prd = rat[rd];

    // RAT: identity after reset; entry 0 is never written so it stays 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                rat[i] <= PREG_WIDTH'(i);
            end
        end else if (alloc) begin
            rat[rd] <= new_prd;
        end
    end

    // Free list: allocation pops at head, release pushes at tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PREG_WIDTH'(NUM_AREG + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_DEPTH);
        end else begin
            if (alloc) begin
                head <= (head == PTR_W'(FL_DEPTH - 1)) ? '0 : head + PTR_W'(1);
            end
            if (release_ok) begin
                fl[tail] <= free_preg_in;
                tail     <= (tail == PTR_W'(FL_DEPTH - 1)) ? '0 : tail + PTR_W'(1);
            end
            case ({alloc, release_ok})
                2'b10:   count <= count - CNT_W'(1);
                2'b01:   count <= count + CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: latch on fire, drop valid when dispatch drains, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            pc_out      <= '0;
            instr_out   <= '0;
            c_sig_out   <= '0;
            alu_sig_out <= '0;
            imm_out     <= '0;
            prs1_out    <= '0;
            prs2_out    <= '0;
            prd_out     <= '0;
            old_prd_out <= '0;
        end else if (fire) begin
            valid_out   <= 1'b1;
            pc_out      <= pc_in;
            instr_out   <= instr_in;
            c_sig_out   <= c_sig_in;
            alu_sig_out <= alu_sig_in;
            imm_out     <= imm_in;
            prs1_out    <= rat[rs1];
            prs2_out    <= rat[rs2];
            prd_out     <= needs_alloc ? new_prd : '0;
            old_prd_out <= needs_alloc ? prev_prd : '0;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: the stimulus process runs a queue-based
// model of the RAT/free list and pushes expected outputs; a negedge monitor
// compares whatever the DUT presents against the head of the queue.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [11:0] pc_in;
    logic [31:0] instr_in;
    logic [6:0]  c_sig_in;
    logic [2:0]  alu_sig_in;
    logic [31:0] imm_in;
    logic        ready_in;
    logic        free_valid_in;
    logic [5:0]  free_preg_in;
    logic        stall_out;
    logic        valid_out;
    logic [11:0] pc_out;
    logic [31:0] instr_out;
    logic [6:0]  c_sig_out;
    logic [2:0]  alu_sig_out;
    logic [31:0] imm_out;
    logic [5:0]  prs1_out;
    logic [5:0]  prs2_out;
    logic [5:0]  prd_out;
    logic [5:0]  old_prd_out;

    rename_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
        .instr_in(instr_in), .c_sig_in(c_sig_in), .alu_sig_in(alu_sig_in),
        .imm_in(imm_in), .ready_in(ready_in), .free_valid_in(free_valid_in),
        .free_preg_in(free_preg_in), .stall_out(stall_out), .valid_out(valid_out),
        .pc_out(pc_out), .instr_out(instr_out), .c_sig_out(c_sig_out),
        .alu_sig_out(alu_sig_out), .imm_out(imm_out), .prs1_out(prs1_out),
        .prs2_out(prs2_out), .prd_out(prd_out), .old_prd_out(old_prd_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pc;
        logic [31:0] instr;
        logic [6:0]  c_sig;
        logic [2:0]  alu;
        logic [31:0] imm;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic [5:0]  prd;
        logic [5:0]  old_prd;
    } exp_t;

    exp_t exp_q[$];
    int   rat_m[32];
    int   fl_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = {7'h00, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat_m[i] = i;
        fl_q.delete();
        for (int i = 32; i < 64; i++) fl_q.push_back(i);
        exp_q.delete();
    endtask

    // Called at posedge+2; leaves at the following posedge+2
    task automatic drive(input logic v, input logic rdy, input logic [31:0] ins,
                         input logic rw, input logic fv, input logic [5:0] fp);
        int   rd, rs1, rs2;
        bit   na, fire, rel_ok;
        exp_t e;
        valid_in      = v;
        ready_in      = rdy;
        instr_in      = ins;
        c_sig_in      = {7'($urandom_range(0, 63)) << 1} | {6'b0, rw};
        pc_in         = 12'($urandom);
        alu_sig_in    = 3'($urandom);
        imm_in        = $urandom;
        free_valid_in = fv;
        free_preg_in  = fp;
        #1;
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        na     = rw && (rd != 0);
        fire   = v && rdy && !(na && fl_q.size() == 0);
        rel_ok = fv && (fp != 0) && (fl_q.size() < 32);
        chk("stall_out", 64'(stall_out), 64'(v && !fire));
        if (fire) begin
            e.pc      = pc_in;
            e.instr   = ins;
            e.c_sig   = c_sig_in;
            e.alu     = alu_sig_in;
            e.imm     = imm_in;
            e.prs1    = 6'(rat_m[rs1]);
            e.prs2    = 6'(rat_m[rs2]);
            e.prd     = 6'd0;
            e.old_prd = 6'd0;
            if (na) begin
                e.prd     = 6'(fl_q.pop_front());
                e.old_prd = 6'(rat_m[rd]);
                rat_m[rd] = int'(e.prd);
            end
            exp_q.push_back(e);
        end
        if (rel_ok) fl_q.push_back(int'(fp));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        valid_in      = 1'b0;
        free_valid_in = 1'b0;
        rst           = 1'b1;
        model_reset();
        #1;
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_payload", {prs1_out, prs2_out, prd_out, old_prd_out, pc_out}, 64'd0);
        chk("reset_stall", 64'(stall_out), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: anything the DUT presents must match the oldest expectation;
    // it is retired when dispatch accepts it
    always @(negedge clk) begin
        exp_t a;
        if (!rst && valid_out) begin
            a = {pc_out, instr_out, c_sig_out, alu_sig_out, imm_out,
                 prs1_out, prs2_out, prd_out, old_prd_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected none", a);
            end else begin
                if (a !== exp_q[0]) begin
                    errors++;
                    $display("FAIL output: got %h expected %h (prd %0d/%0d old %0d/%0d)",
                             a, exp_q[0], prd_out, exp_q[0].prd, old_prd_out, exp_q[0].old_prd);
                end
                if (ready_in) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int rel_pct;
        rst = 1'b0;
        valid_in = 0; ready_in = 1; pc_in = 0; instr_in = 0; c_sig_in = 0;
        alu_sig_in = 0; imm_in = 0; free_valid_in = 0; free_preg_in = 0;
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("por_valid_out", 64'(valid_out), 64'd0);
        chk("por_payload", {prd_out, old_prd_out, prs1_out, prs2_out, c_sig_out}, 64'd0);
        rst = 1'b0;

        // idle, then a release while the list is full is ignored
        drive(0, 1, 32'd0, 0, 0, 0);
        drive(0, 1, 32'd0, 0, 1, 6'd40);
        chk("idle_valid_out", 64'(valid_out), 64'd0);

        // dependent pair
        drive(1, 1, mk(1, 2, 3), 1, 0, 0);
        chk("add1_prd", 64'(prd_out), 64'd32);
        chk("add1_old", 64'(old_prd_out), 64'd1);
        drive(1, 1, mk(4, 1, 1), 1, 0, 0);
        chk("add2_prs1", 64'(prs1_out), 64'd32);
        chk("add2_prd", 64'(prd_out), 64'd33);

        // x0 destination and non-writing store
        drive(1, 1, mk(0, 4, 1), 1, 0, 0);
        chk("x0_prd", 64'(prd_out), 64'd0);
        drive(1, 1, mk(5, 4, 1), 0, 0, 0);
        chk("store_old", 64'(old_prd_out), 64'd0);
        drive(1, 1, mk(6, 0, 0), 1, 0, 0);
        chk("after_x0_prd", 64'(prd_out), 64'd34);

        // exhaust the free list
        do_reset();
        for (int i = 0; i < 32; i++) drive(1, 1, mk((i % 31) + 1, i % 32, (i + 3) % 32), 1, 0, 0);
        drive(1, 1, mk(7, 1, 2), 1, 0, 0);
        chk("empty_valid_drop", 64'(valid_out), 64'd0);
        drive(1, 1, mk(7, 1, 2), 1, 1, 6'd5);
        drive(1, 1, mk(7, 1, 2), 1, 0, 0);
        chk("refill_prd", 64'(prd_out), 64'd5);

        // backpressure hold
        drive(0, 1, 32'd0, 0, 1, 6'd10);
        drive(0, 1, 32'd0, 0, 1, 6'd11);
        drive(1, 1, mk(8, 7, 3), 1, 1, 6'd12);
        repeat (3) drive(1, 0, mk(9, 8, 8), 1, 0, 0);
        chk("hold_prd", 64'(prd_out), 64'd10);
        drive(1, 1, mk(9, 8, 8), 1, 0, 0);
        chk("release_prd", 64'(prd_out), 64'd11);
        chk("release_prs1", 64'(prs1_out), 64'd10);

        // reset mid-stream
        for (int i = 0; i < 10; i++) drive(1, 1, mk(i + 1, i, i + 2), 1, 0, 0);
        do_reset();
        drive(1, 1, mk(3, 3, 1), 1, 0, 0);
        chk("post_reset_prd", 64'(prd_out), 64'd32);
        chk("post_reset_prs1", 64'(prs1_out), 64'd3);

        // randomized traffic with alternating release pressure
        for (int i = 0; i < 2000; i++) begin
            rel_pct = ((i / 250) % 2 == 0) ? 15 : 70;
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75,
                  $urandom, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < rel_pct, 6'($urandom));
        end

        // drain
        repeat (3) drive(0, 1, 32'd0, 0, 0, 0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
